inst_queue_mp: RTL and testbench

- Parametrised multi-port instruction queue between the fetch stage and the decode/issue stage.
- Accepts up to WR_PORTS fetched instructions (with their PCs) per cycle.
- Presents up to RD_PORTS oldest entries to issue; issue pops any in-order prefix of them.
- Adds exact occupancy and free-slot reporting, overflow detection, and a delay-slot flush mode: one entry survives a redirect and is later issued alone.

---
 rtl/inst_queue_mp_if.sv | 39 +++
 rtl/inst_queue_mp.sv | 176 +++++++++++++++++
 tb/tb_inst_queue_mp.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_mp_if.sv
// Fetch/issue-side bundle for the multi-port instruction queue.
// master = fetch/issue logic driving the queue; slave = the queue itself.
interface inst_queue_mp_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2,
  parameter int CNT_W    = $clog2(DEPTH) + 1
);
  logic                         flush;
  logic                         flush_keep;
  logic [WR_PORTS-1:0]          wr_valid;
  logic [WR_PORTS*DATA_W-1:0]   wr_data;
  logic [WR_PORTS*ADDR_W-1:0]   wr_pc;
  logic [RD_PORTS-1:0]          rd_req;
  logic [RD_PORTS-1:0]          rd_valid;
  logic [RD_PORTS*DATA_W-1:0]   rd_data;
  logic [RD_PORTS*ADDR_W-1:0]   rd_pc;
  logic                         rd_is_ds;
  logic [CNT_W-1:0]             count;
  logic                         empty;
  logic                         full;
  logic                         overflow;
  logic                         ds_wait;
  logic [63:0]                  issued_total;

  modport master (
    output flush, flush_keep, wr_valid, wr_data, wr_pc, rd_req,
    input  rd_valid, rd_data, rd_pc, rd_is_ds, count, empty, full,
           overflow, ds_wait, issued_total
  );

  modport slave (
    input  flush, flush_keep, wr_valid, wr_data, wr_pc, rd_req,
    output rd_valid, rd_data, rd_pc, rd_is_ds, count, empty, full,
           overflow, ds_wait, issued_total
  );
endinterface

// File: rtl/inst_queue_mp.sv
// Multi-port instruction queue, fetch to issue; writes visible on rd_* one cycle after accept.
// No stall: a write cycle that does not fit is dropped whole and flagged sticky in overflow.
module inst_queue_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  inst_queue_mp_if.slave q
);
  localparam int PTR_W = CNT_W - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            mem [DEPTH];

  logic [PTR_W-1:0]  head, head_n;
  logic [PTR_W-1:0]  tail, tail_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              ds_flag, ds_flag_n;
  logic              ds_wait, ds_wait_n;
  logic              overflow, overflow_n;
  logic [63:0]       issued_total, issued_n;

  logic [RD_PORTS-1:0] rd_vld;
  logic [CNT_W-1:0]    pop;
  logic [CNT_W-1:0]    push;
  logic [CNT_W-1:0]    space;
  logic                push_ok;
  entry_t              keep_ent;
  entry_t              lane_ent [WR_PORTS];

  logic [WR_PORTS-1:0] wen;
  logic [PTR_W-1:0]    waddr [WR_PORTS];
  entry_t              wdat  [WR_PORTS];

  // Read lanes: only the head lane is exposed while a delay-slot entry sits there.
  always_comb begin
    rd_vld    = '0;
    q.rd_data = '0;
    q.rd_pc   = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_vld[i] = (CNT_W'(i) < count) && !(ds_flag && (i > 0));
      if (rd_vld[i]) begin
        q.rd_data[i*DATA_W +: DATA_W] = mem[head + PTR_W'(i)].data;
        q.rd_pc[i*ADDR_W +: ADDR_W]   = mem[head + PTR_W'(i)].pc;
      end
    end
  end

  always_comb begin
    pop  = '0;
    push = '0;
    for (int i = 0; i < RD_PORTS; i++)
      pop = pop + CNT_W'(q.rd_req[i] & rd_vld[i]);
    for (int i = 0; i < WR_PORTS; i++)
      push = push + CNT_W'(q.wr_valid[i]);
  end

  // Space is judged before this cycle's pops; issue and fetch are not coupled.
  assign space    = CNT_W'(DEPTH) - count;
  assign push_ok  = (push <= space);
  assign keep_ent = mem[head + pop[PTR_W-1:0]];

  always_comb begin
    for (int i = 0; i < WR_PORTS; i++)
      lane_ent[i] = '{data: q.wr_data[i*DATA_W +: DATA_W], pc: q.wr_pc[i*ADDR_W +: ADDR_W]};
  end

  always_comb begin
    head_n     = head;
    tail_n     = tail;
    count_n    = count;
    ds_flag_n  = ds_flag;
    ds_wait_n  = ds_wait;
    overflow_n = overflow;
    issued_n   = issued_total + 64'(pop);
    wen        = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      waddr[i] = tail + PTR_W'(i);
      wdat[i]  = lane_ent[i];
    end

    if (q.flush) begin
      head_n     = '0;
      tail_n     = '0;
      count_n    = '0;
      ds_flag_n  = 1'b0;
      ds_wait_n  = 1'b0;
      overflow_n = 1'b0;
      if (q.flush_keep) begin
        // Survivor is the oldest entry not issued this cycle, else fetch lane 0.
        if (count > pop) begin
          wen[0]    = 1'b1;
          waddr[0]  = '0;
          wdat[0]   = keep_ent;
          tail_n    = PTR_W'(1);
          count_n   = CNT_W'(1);
          ds_flag_n = 1'b1;
        end else if (q.wr_valid[0]) begin
          wen[0]    = 1'b1;
          waddr[0]  = '0;
          tail_n    = PTR_W'(1);
          count_n   = CNT_W'(1);
          ds_flag_n = 1'b1;
        end else begin
          ds_wait_n = 1'b1;
        end
      end
    end else if (ds_wait) begin
      // Queue is empty with pointers at 0; the next fetched lane 0 is the delay slot.
      if (q.wr_valid[0]) begin
        wen[0]    = 1'b1;
        waddr[0]  = '0;
        tail_n    = PTR_W'(1);
        count_n   = CNT_W'(1);
        ds_flag_n = 1'b1;
        ds_wait_n = 1'b0;
      end
    end else begin
      if (q.rd_req[0] && rd_vld[0])
        ds_flag_n = 1'b0;
      if (push_ok) begin
        wen     = q.wr_valid;
        tail_n  = tail + push[PTR_W-1:0];
        count_n = count + push - pop;
      end else begin
        overflow_n = 1'b1;
        count_n    = count - pop;
      end
      head_n = head + pop[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ds_flag      <= 1'b0;
      ds_wait      <= 1'b0;
      overflow     <= 1'b0;
      issued_total <= '0;
    end else begin
      head         <= head_n;
      tail         <= tail_n;
      count        <= count_n;
      ds_flag      <= ds_flag_n;
      ds_wait      <= ds_wait_n;
      overflow     <= overflow_n;
      issued_total <= issued_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++)
      if (wen[i])
        mem[waddr[i]] <= wdat[i];
  end

  assign q.rd_valid     = rd_vld;
  assign q.rd_is_ds     = ds_flag;
  assign q.count        = count;
  assign q.empty        = (count == '0);
  assign q.full         = (space < CNT_W'(WR_PORTS));
  assign q.overflow     = overflow;
  assign q.ds_wait      = ds_wait;
  assign q.issued_total = issued_total;
endmodule

// File: tb/tb_inst_queue_mp.sv
// Scoreboard bench for inst_queue_mp: expected entries queued on accepted writes, compared on pop.
module tb_inst_queue_mp;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_issued;

  inst_queue_mp_if q ();
  inst_queue_mp dut (.clk(clk), .rst(rst), .q(q));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic idle();
    q.flush      = 1'b0;
    q.flush_keep = 1'b0;
    q.wr_valid   = '0;
    q.wr_data    = '0;
    q.wr_pc      = '0;
    q.rd_req     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int n, input logic [31:0] d0, input logic [31:0] p0,
                          input logic [31:0] d1, input logic [31:0] p1);
    q.wr_valid = 2'((1 << n) - 1);
    q.wr_data  = {d1, d0};
    q.wr_pc    = {p1, p0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (q.count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", q.count); end
    tests++; if (q.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", q.empty); end
    tests++; if ({q.full, q.overflow, q.ds_wait, q.rd_is_ds} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {q.full, q.overflow, q.ds_wait, q.rd_is_ds}); end
    tests++; if (q.rd_valid !== 2'b00 || q.rd_data !== 64'd0) begin fails++; $display("FAIL reset_rd: got valid %b data %0h want 0", q.rd_valid, q.rd_data); end
    tests++; if (q.issued_total !== 64'd0) begin fails++; $display("FAIL reset_issued: got %0d want 0", q.issued_total); end
    rst = 1'b0;
    tick();
    exp_issued = '0;
    sb.delete();
  endtask

  task automatic test_basic();
    drive_wr(2, 32'hAAAA_0001, 32'h100, 32'hBBBB_0002, 32'h104);
    sb.push_back('{d: 32'hAAAA_0001, pc: 32'h100});
    sb.push_back('{d: 32'hBBBB_0002, pc: 32'h104});
    tick(); idle();
    tests++; if (q.rd_valid !== 2'b11) begin fails++; $display("FAIL basic_valid: got %b want 11", q.rd_valid); end
    tests++; if (q.count !== 5'd2) begin fails++; $display("FAIL basic_count: got %0d want 2", q.count); end
    q.rd_req = 2'b11;
    for (int l = 0; l < 2; l++) begin
      tests++; if (q.rd_data[l*32 +: 32] !== sb[0].d || q.rd_pc[l*32 +: 32] !== sb[0].pc) begin
        fails++; $display("FAIL basic_lane%0d: got %h@%h want %h@%h", l, q.rd_data[l*32 +: 32], q.rd_pc[l*32 +: 32], sb[0].d, sb[0].pc);
      end
      void'(sb.pop_front());
    end
    exp_issued += 2;
    tick(); idle();
    tests++; if (q.count !== 5'd0 || q.empty !== 1'b1) begin fails++; $display("FAIL basic_drain: got count %0d empty %b want 0 1", q.count, q.empty); end
    tests++; if (q.issued_total !== exp_issued) begin fails++; $display("FAIL basic_issued: got %0d want %0d", q.issued_total, exp_issued); end
    // Requests against an empty queue must not underflow.
    q.rd_req = 2'b11;
    tick(); idle();
    tests++; if (q.count !== 5'd0 || q.issued_total !== exp_issued) begin fails++; $display("FAIL basic_underflow: got count %0d issued %0d want 0 %0d", q.count, q.issued_total, exp_issued); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 8; k++) begin
      int n;
      n = (k == 7) ? 1 : 2;
      drive_wr(n, 32'hC000_0000 + 32'(2*k), 32'h2000 + 32'(8*k), 32'hC000_0001 + 32'(2*k), 32'h2004 + 32'(8*k));
      sb.push_back('{d: 32'hC000_0000 + 32'(2*k), pc: 32'h2000 + 32'(8*k)});
      if (n == 2) sb.push_back('{d: 32'hC000_0001 + 32'(2*k), pc: 32'h2004 + 32'(8*k)});
      tick();
    end
    idle();
    tests++; if (q.count !== 5'd15 || q.full !== 1'b1 || q.overflow !== 1'b0) begin fails++; $display("FAIL ovf_fill: got count %0d full %b ovf %b want 15 1 0", q.count, q.full, q.overflow); end
    drive_wr(2, 32'hDEAD_0000, 32'hDEAD, 32'hDEAD_0001, 32'hDEAE);
    q.rd_req = 2'b01;
    tests++; if (q.rd_data[31:0] !== sb[0].d) begin fails++; $display("FAIL ovf_pop: got %h want %h", q.rd_data[31:0], sb[0].d); end
    void'(sb.pop_front());
    exp_issued += 1;
    tick(); idle();
    tests++; if (q.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", q.overflow); end
    tests++; if (q.count !== 5'd14 || q.full !== 1'b0) begin fails++; $display("FAIL ovf_count: got count %0d full %b want 14 0", q.count, q.full); end
    tests++; if (q.rd_data[31:0] !== sb[0].d || q.rd_data[63:32] !== sb[1].d) begin fails++; $display("FAIL ovf_head: got %h want %h_%h", q.rd_data, sb[1].d, sb[0].d); end
  endtask

  task automatic test_wrap();
    int wrote, cyc, nv, n, np;
    logic [1:0] expv;
    logic [31:0] seq;
    q.flush = 1'b1;
    tick(); idle();
    sb.delete();
    tests++; if (q.overflow !== 1'b0 || q.count !== 5'd0) begin fails++; $display("FAIL flush_clear: got ovf %b count %0d want 0 0", q.overflow, q.count); end
    wrote = 0; cyc = 0; seq = 32'd0;
    while (wrote < 40 && cyc < 400) begin
      nv   = (sb.size() < 2) ? sb.size() : 2;
      n    = $urandom_range(0, 2);
      np   = (n < nv) ? n : nv;
      expv = 2'((1 << nv) - 1);
      tests++; if (q.rd_valid !== expv || q.count !== 5'(sb.size())) begin fails++; $display("FAIL wrap_state c%0d: got valid %b count %0d want %b %0d", cyc, q.rd_valid, q.count, expv, sb.size()); end
      q.rd_req = 2'((1 << n) - 1);
      for (int l = 0; l < np; l++) begin
        tests++; if (q.rd_data[l*32 +: 32] !== sb[l].d || q.rd_pc[l*32 +: 32] !== sb[l].pc) begin
          fails++; $display("FAIL wrap_data c%0d l%0d: got %h@%h want %h@%h", cyc, l, q.rd_data[l*32 +: 32], q.rd_pc[l*32 +: 32], sb[l].d, sb[l].pc);
        end
      end
      if (16 - sb.size() >= 2) begin
        drive_wr(2, 32'h5000_0000 + seq, 32'h4000 + 4*seq, 32'h5000_0001 + seq, 32'h4004 + 4*seq);
        sb.push_back('{d: 32'h5000_0000 + seq, pc: 32'h4000 + 4*seq});
        sb.push_back('{d: 32'h5000_0001 + seq, pc: 32'h4004 + 4*seq});
        seq += 2;
        wrote++;
      end
      for (int l = 0; l < np; l++) void'(sb.pop_front());
      exp_issued += 64'(np);
      tick(); idle();
      cyc++;
    end
    tests++; if (wrote != 40) begin fails++; $display("FAIL wrap_budget: got %0d writes want 40", wrote); end
    tests++; if (q.count !== 5'(sb.size()) || q.count > 5'd16) begin fails++; $display("FAIL wrap_count: got %0d want %0d", q.count, sb.size()); end
    tests++; if (q.issued_total !== exp_issued) begin fails++; $display("FAIL wrap_issued: got %0d want %0d", q.issued_total, exp_issued); end
  endtask

  task automatic test_ds_keep();
    q.flush = 1'b1;
    tick(); idle();
    sb.delete();
    drive_wr(2, 32'h0000_00A1, 32'h800, 32'h0000_00B2, 32'h804);
    tick();
    drive_wr(1, 32'h0000_00C3, 32'h808, 32'h0, 32'h0);
    tick(); idle();
    tests++; if (q.count !== 5'd3) begin fails++; $display("FAIL ds_setup: got %0d want 3", q.count); end
    q.rd_req = 2'b01; q.flush = 1'b1; q.flush_keep = 1'b1;
    tests++; if (q.rd_data[31:0] !== 32'h0000_00A1) begin fails++; $display("FAIL ds_pop_x: got %h want a1", q.rd_data[31:0]); end
    exp_issued += 1;
    sb.push_back('{d: 32'h0000_00B2, pc: 32'h804});
    tick(); idle();
    tests++; if (q.count !== 5'd1 || q.rd_valid !== 2'b01 || q.rd_is_ds !== 1'b1) begin fails++; $display("FAIL ds_keep: got count %0d valid %b ds %b want 1 01 1", q.count, q.rd_valid, q.rd_is_ds); end
    tests++; if (q.rd_data[31:0] !== sb[0].d || q.rd_pc[31:0] !== sb[0].pc) begin fails++; $display("FAIL ds_keep_y: got %h@%h want %h@%h", q.rd_data[31:0], q.rd_pc[31:0], sb[0].d, sb[0].pc); end
    drive_wr(2, 32'h0000_00D4, 32'h900, 32'h0000_00E5, 32'h904);
    sb.push_back('{d: 32'h0000_00D4, pc: 32'h900});
    sb.push_back('{d: 32'h0000_00E5, pc: 32'h904});
    tick(); idle();
    tests++; if (q.rd_valid !== 2'b01 || q.count !== 5'd3) begin fails++; $display("FAIL ds_hidden: got valid %b count %0d want 01 3", q.rd_valid, q.count); end
    tests++; if (q.rd_data[63:32] !== 32'd0 || q.rd_pc[63:32] !== 32'd0) begin fails++; $display("FAIL ds_lane1_zero: got %h@%h want 0", q.rd_data[63:32], q.rd_pc[63:32]); end
    q.rd_req = 2'b11;
    tests++; if (q.rd_data[31:0] !== sb[0].d) begin fails++; $display("FAIL ds_pop_y: got %h want %h", q.rd_data[31:0], sb[0].d); end
    void'(sb.pop_front());
    exp_issued += 1;
    tick(); idle();
    tests++; if (q.rd_is_ds !== 1'b0 || q.rd_valid !== 2'b11 || q.count !== 5'd2) begin fails++; $display("FAIL ds_release: got ds %b valid %b count %0d want 0 11 2", q.rd_is_ds, q.rd_valid, q.count); end
    q.rd_req = 2'b11;
    for (int l = 0; l < 2; l++) begin
      tests++; if (q.rd_data[l*32 +: 32] !== sb[0].d || q.rd_pc[l*32 +: 32] !== sb[0].pc) begin
        fails++; $display("FAIL ds_behind_l%0d: got %h@%h want %h@%h", l, q.rd_data[l*32 +: 32], q.rd_pc[l*32 +: 32], sb[0].d, sb[0].pc);
      end
      void'(sb.pop_front());
    end
    exp_issued += 2;
    tick(); idle();
    tests++; if (q.empty !== 1'b1 || q.issued_total !== exp_issued) begin fails++; $display("FAIL ds_end: got empty %b issued %0d want 1 %0d", q.empty, q.issued_total, exp_issued); end
  endtask

  task automatic test_ds_wait();
    q.flush = 1'b1; q.flush_keep = 1'b1;
    tick(); idle();
    tests++; if (q.ds_wait !== 1'b1 || q.empty !== 1'b1 || q.rd_valid !== 2'b00) begin fails++; $display("FAIL dsw_enter: got wait %b empty %b valid %b want 1 1 00", q.ds_wait, q.empty, q.rd_valid); end
    tick();
    tests++; if (q.ds_wait !== 1'b1 || q.count !== 5'd0) begin fails++; $display("FAIL dsw_hold: got wait %b count %0d want 1 0", q.ds_wait, q.count); end
    drive_wr(2, 32'h0000_0F01, 32'hA00, 32'h0000_0F02, 32'hA04);
    sb.push_back('{d: 32'h0000_0F01, pc: 32'hA00});
    tick(); idle();
    tests++; if (q.count !== 5'd1 || q.ds_wait !== 1'b0 || q.rd_is_ds !== 1'b1 || q.empty !== 1'b0) begin fails++; $display("FAIL dsw_fill: got count %0d wait %b ds %b empty %b want 1 0 1 0", q.count, q.ds_wait, q.rd_is_ds, q.empty); end
    tests++; if (q.rd_data[31:0] !== sb[0].d || q.rd_pc[31:0] !== sb[0].pc || q.rd_valid !== 2'b01) begin fails++; $display("FAIL dsw_p: got %h@%h v%b want %h@%h v01", q.rd_data[31:0], q.rd_pc[31:0], q.rd_valid, sb[0].d, sb[0].pc); end
    // A plain flush while holding a delay slot discards it.
    q.flush = 1'b1;
    tick(); idle();
    sb.delete();
    tests++; if (q.count !== 5'd0 || q.rd_is_ds !== 1'b0) begin fails++; $display("FAIL dsw_reflush: got count %0d ds %b want 0 0", q.count, q.rd_is_ds); end
    q.flush = 1'b1; q.flush_keep = 1'b1;
    drive_wr(2, 32'h0000_0E01, 32'hB00, 32'h0000_0E02, 32'hB04);
    sb.push_back('{d: 32'h0000_0E01, pc: 32'hB00});
    tick(); idle();
    tests++; if (q.count !== 5'd1 || q.rd_is_ds !== 1'b1 || q.ds_wait !== 1'b0 || q.rd_data[31:0] !== sb[0].d) begin fails++; $display("FAIL dsw_lane0: got count %0d ds %b wait %b data %h want 1 1 0 %h", q.count, q.rd_is_ds, q.ds_wait, q.rd_data[31:0], sb[0].d); end
    q.rd_req = 2'b01;
    void'(sb.pop_front());
    exp_issued += 1;
    tick(); idle();
    tests++; if (q.empty !== 1'b1 || q.issued_total !== exp_issued) begin fails++; $display("FAIL dsw_end: got empty %b issued %0d want 1 %0d", q.empty, q.issued_total, exp_issued); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 8; k++) begin
      drive_wr((k == 7) ? 1 : 2, 32'h7000_0000 + 32'(k), 32'h6000, 32'h7100_0000 + 32'(k), 32'h6004);
      tick();
    end
    drive_wr(2, 32'h1, 32'h1, 32'h2, 32'h2);
    tick(); idle();
    q.rd_req = 2'b11;
    repeat (4) tick();
    idle();
    tests++; if (q.count !== 5'd7 || q.overflow !== 1'b1) begin fails++; $display("FAIL arst_setup: got count %0d ovf %b want 7 1", q.count, q.overflow); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (q.count !== 5'd0 || q.empty !== 1'b1 || q.overflow !== 1'b0) begin fails++; $display("FAIL arst_clear: got count %0d empty %b ovf %b want 0 1 0", q.count, q.empty, q.overflow); end
    tests++; if (q.issued_total !== 64'd0 || q.rd_valid !== 2'b00) begin fails++; $display("FAIL arst_issued: got %0d valid %b want 0 00", q.issued_total, q.rd_valid); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_ds_keep();
    test_ds_wait();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
